// File: rtl/id_rob_queue.sv
// id_rob_queue: elastic valid/ready queue between ID and ROB dispatch with flush and occupancy
module id_rob_queue #(
    parameter int WIDTH     = 160,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready    = (count != FULL) & ~flush;
    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign almost_full = (count >= AF);
    assign push        = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;

    // payload array: written on accepted push only, contents masked by out_valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // pointers and occupancy; flush outranks push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_id_rob_queue.sv
// tb_id_rob_queue: directed checks of fill, drain, streaming, full-pop, flush and async reset
module tb_id_rob_queue;
    localparam int WIDTH = 160;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             almost_full;

    int compared = 0;
    int mismatched = 0;

    id_rob_queue #(.WIDTH(WIDTH), .DEPTH(4), .AF_THRESH(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .almost_full(almost_full)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] drain_exp [4];
        drain_exp = '{160'h2, 160'h3, 160'h4, 160'hAA};
        #2;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_almost_full", almost_full, 0);
        #1 rst = 1'b1;
        tick();

        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(i);
            #1 check("fill_in_ready", in_ready, 1);
            tick();
            check("fill_count", count, WIDTH'(i));
            check("fill_almost_full", almost_full, (i >= 3) ? 1 : 0);
        end
        in_valid = 1'b0;
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head", out_data, 160'h1);

        in_valid = 1'b1;
        in_data = 160'hAA;
        out_ready = 1'b1;
        #1 check("fullpop_in_ready", in_ready, 0);
        tick();
        check("fullpop_count", count, 3);
        check("fullpop_head", out_data, 160'h2);
        check("fullpop_in_ready_after", in_ready, 1);
        out_ready = 1'b0;
        tick();
        check("fullpop_refill_count", count, 4);
        in_valid = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("drain_data", out_data, drain_exp[i]);
            tick();
        end
        check("drain_count", count, 0);
        check("drain_out_valid", out_valid, 0);
        check("drain_out_data", out_data, 0);
        tick();
        check("empty_pop_ignored", count, 0);

        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(16 + k);
            tick();
            check("stream_count", count, 1);
            check("stream_data", out_data, WIDTH'(16 + k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_count", count, 0);
        out_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(8'h31 + i);
            tick();
        end
        check("flush_pre_count", count, 2);
        flush = 1'b1;
        in_data = 160'h33;
        out_ready = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, 0);
        in_valid = 1'b1;
        in_data = 160'h34;
        #1 check("postflush_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("postflush_count", count, 1);
        check("postflush_data", out_data, 160'h34);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("postflush_drain", count, 0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(8'h41 + i);
            tick();
        end
        in_valid = 1'b0;
        check("arst_pre_count", count, 3);
        check("arst_pre_head", out_data, 160'h41);
        #2 rst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_almost_full", almost_full, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 160'h55;
        tick();
        in_valid = 1'b0;
        check("arst_push_data", out_data, 160'h55);
        check("arst_push_count", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
